instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction ROM. It owns the program counter and drives ROM chip-enable, read and address. It captures the ROM's same-cycle combinational read data into a small prefetch FIFO and presents {pc, instr, fault} to decode with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and reload the PC.

---
 rtl/riscv1_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv1_pkg.sv
// Shared fetch-stage types and constants for the riscv1 front end.
package riscv1_pkg;
    localparam int          INSTR_W = 32;
    localparam int          ADDR_W  = 32;
    localparam logic [31:0] NOP     = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Bit order matches the prefetch FIFO word: {fault, pc, instr}.
    typedef struct packed {
        logic              fault;
        logic [ADDR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head word is read straight from storage.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [3:0]   o_level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == 4'(DEPTH));
    assign o_empty = (r_level == 4'd0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + 4'(w_push) - 4'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, fetch FSM, ROM range/alignment check and prefetch FIFO feeding decode.
module instr_fetch
    import riscv1_pkg::*;
#(
    parameter logic [31:0] ROM_ORIGIN   = 32'h0,
    parameter logic [31:0] ROM_LENGTH   = 32'h400,
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        iIF_CLK,
    input  logic        iIF_RSTn,
    output logic        oROM_CE,
    output logic        oROM_RD,
    output logic [31:0] oROM_ADDR,
    input  logic [31:0] iROM_DATA,
    input  logic        iIF_READY,
    output logic        oIF_VALID,
    output logic [31:0] oIF_INSTR,
    output logic [31:0] oIF_PC,
    output logic        oIF_FAULT,
    input  logic        iIF_REDIRECT,
    input  logic [31:0] iIF_TARGET,
    output logic [3:0]  oIF_LEVEL
);
    fetch_state_e r_state, w_next_state;
    logic [31:0]  r_pc, w_next_pc;
    logic [32:0]  w_off;
    logic         w_fault, w_ce, w_push, w_pop, w_valid, w_room;
    logic         w_full, w_empty;
    logic [3:0]   w_level;
    fetch_entry_t w_push_data, w_head;

    // Offset from the window base; a borrow means the PC sits below the ROM.
    assign w_off   = {1'b0, r_pc} - {1'b0, ROM_ORIGIN};
    assign w_fault = (r_pc[1:0] != 2'b00) || w_off[32] || (w_off[31:0] >= ROM_LENGTH);

    assign w_valid = !w_empty && !iIF_REDIRECT;
    assign w_pop   = w_valid && iIF_READY;
    assign w_room  = !w_full || w_pop;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_ce         = 1'b0;
        w_push       = 1'b0;
        w_push_data  = '0;
        case (r_state)
            IDLE:  w_next_state = FETCH;
            FETCH: begin
                if (w_room) begin
                    w_push         = 1'b1;
                    w_push_data.pc = r_pc;
                    if (w_fault) begin
                        w_push_data.fault = 1'b1;
                        w_next_state      = HALT;
                    end else begin
                        w_ce              = 1'b1;
                        w_push_data.instr = iROM_DATA;
                        w_next_pc         = r_pc + 32'd4;
                    end
                end
            end
            default: ;
        endcase
        // Redirect overrides everything, including the IDLE cycle.
        if (iIF_REDIRECT) begin
            w_next_state = FETCH;
            w_next_pc    = iIF_TARGET;
            w_ce         = 1'b0;
            w_push       = 1'b0;
        end
    end

    always_ff @(posedge iIF_CLK or negedge iIF_RSTn) begin
        if (!iIF_RSTn) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (iIF_CLK),
        .i_rst_n (iIF_RSTn),
        .i_flush (iIF_REDIRECT),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign oROM_CE   = w_ce;
    assign oROM_RD   = w_ce;
    assign oROM_ADDR = r_pc;
    assign oIF_VALID = w_valid;
    assign oIF_INSTR = w_empty ? 32'h0 : w_head.instr;
    assign oIF_PC    = w_empty ? 32'h0 : w_head.pc;
    assign oIF_FAULT = w_empty ? 1'b0  : w_head.fault;
    assign oIF_LEVEL = w_level;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences, random run vs queue model.
module tb_instr_fetch;
    localparam logic [31:0] ORG   = 32'h0;
    localparam logic [31:0] LEN   = 32'h400;
    localparam logic [31:0] RV    = 32'h0;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        ce, rd, valid, fault;
    logic [31:0] addr, rdata, instr, pc;
    logic [3:0]  level;

    instr_fetch #(
        .ROM_ORIGIN(ORG), .ROM_LENGTH(LEN), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .iIF_CLK(clk), .iIF_RSTn(rst_n),
        .oROM_CE(ce), .oROM_RD(rd), .oROM_ADDR(addr), .iROM_DATA(rdata),
        .iIF_READY(ready), .oIF_VALID(valid), .oIF_INSTR(instr), .oIF_PC(pc),
        .oIF_FAULT(fault), .iIF_REDIRECT(redir), .iIF_TARGET(tgt), .oIF_LEVEL(level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA0 + {2'b00, a[31:2]};
    endfunction

    assign rdata = rom_word(addr);

    // Reference model: expected decode-side queue plus PC and run phase (0 idle, 1 run, 2 halted).
    typedef struct packed {logic f; logic [31:0] pc; logic [31:0] ins;} ent_t;
    ent_t        q[$];
    logic [31:0] m_pc = RV;
    int          m_phase = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic bit m_fault(input logic [31:0] a);
        longint o;
        o = longint'(a) - longint'(ORG);
        return (a[1:0] != 2'b00) || (o < 0) || (o >= longint'(LEN));
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        ent_t         head;
        bit           mv, pop, slot, mf;
        logic [103:0] act, exp;
        head = (q.size() != 0) ? q[0] : '0;
        mv   = (q.size() != 0) && !redir;
        pop  = mv && ready;
        slot = (m_phase == 1) && !redir && ((q.size() < DEPTH) || pop);
        mf   = m_fault(m_pc);
        exp  = {slot && !mf, slot && !mf, m_pc, mv, head.f, head.pc, head.ins, 4'(q.size())};
        act  = {ce, rd, addr, valid, fault, pc, instr, level};
        chk("model", act, exp);
        if (redir) begin
            q.delete();
            m_pc    = tgt;
            m_phase = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_phase == 0) m_phase = 1;
            else if (slot) begin
                if (mf) begin
                    q.push_back({1'b1, m_pc, 32'h0});
                    m_phase = 2;
                end else begin
                    q.push_back({1'b0, m_pc, rom_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic sample(); @(negedge clk); model_step(); endtask
    task automatic adv(); @(posedge clk); #1; endtask
    task automatic cyc(); sample(); adv(); endtask

    task automatic do_reset();
        rst_n = 1'b0; redir = 1'b0; ready = 1'b0;
        #2;
        chk("reset_outs", {ce, rd, valid, fault, pc, instr, level, addr},
            {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, RV});
        q.delete();
        m_pc = RV;
        m_phase = 0;
        adv();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rst; bit rdy; bit rdr; logic [31:0] tg;
        bit ce; logic [31:0] ad; bit v; logic [31:0] hp; logic [3:0] lv;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ce_any;
        //          rst rdy rdr tgt       ce addr      v  head pc   lvl
        tbl[0]  = '{1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   4'd0};
        tbl[1]  = '{0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   4'd0};
        tbl[2]  = '{0, 1, 0, 32'h0,   1, 32'h4,   1, 32'h0,   4'd1};
        tbl[3]  = '{0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4,   4'd1};
        tbl[4]  = '{0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   4'd1};
        tbl[5]  = '{1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   4'd0};
        tbl[6]  = '{0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   4'd0};
        tbl[7]  = '{0, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   4'd1};
        tbl[8]  = '{0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0,   4'd2};
        tbl[9]  = '{0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0,   4'd2};
        tbl[10] = '{0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0,   4'd2};
        tbl[11] = '{0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4,   4'd2};
        tbl[12] = '{0, 0, 0, 32'h0,   0, 32'h10,  1, 32'h8,   4'd2};
        tbl[13] = '{0, 1, 1, 32'h100, 0, 32'h10,  0, 32'h0,   4'd2};
        tbl[14] = '{0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   4'd0};
        tbl[15] = '{0, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100, 4'd1};

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            ready = tbl[i].rdy; redir = tbl[i].rdr; tgt = tbl[i].tg;
            sample();
            chk($sformatf("vec%0d", i), {ce, addr, valid, level},
                {tbl[i].ce, tbl[i].ad, tbl[i].v, tbl[i].lv});
            if (tbl[i].v)
                chk($sformatf("vec%0d_head", i), {pc, instr, fault},
                    {tbl[i].hp, rom_word(tbl[i].hp), 1'b0});
            adv();
        end

        // Redirect with one entry waiting and decode ready: no handshake, FIFO flushed.
        ready = 1'b1; redir = 1'b1; tgt = 32'h200;
        sample(); chk("rdr_pop_blocked", {valid, level}, {1'b0, 4'd1}); adv();
        redir = 1'b0;
        sample(); chk("rdr_flushed", {valid, level, ce, addr}, {1'b0, 4'd0, 1'b1, 32'h200}); adv();

        // Stream into the end of the ROM window.
        redir = 1'b1; tgt = 32'h3F0; cyc(); redir = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        sample();
        chk("eor_last", {valid, fault, pc, instr}, {1'b1, 1'b0, 32'h3FC, rom_word(32'h3FC)});
        chk("eor_noaccess", {ce, addr}, {1'b0, 32'h400});
        adv();
        sample(); chk("eor_fault", {valid, fault, pc, instr}, {1'b1, 1'b1, 32'h400, 32'h0}); adv();
        ce_any = 1'b0;
        for (int i = 0; i < 6; i++) begin sample(); ce_any |= ce; adv(); end
        chk("halt_nofetch", {ce_any, level, addr}, {1'b0, 4'd0, 32'h400});

        // Misaligned redirect, then recovery.
        redir = 1'b1; tgt = 32'h102; cyc(); redir = 1'b0;
        sample(); chk("mis_noce", {ce, addr}, {1'b0, 32'h102}); adv();
        sample(); chk("mis_fault", {valid, fault, pc, instr}, {1'b1, 1'b1, 32'h102, 32'h0}); adv();
        cyc();
        redir = 1'b1; tgt = 32'h0; cyc(); redir = 1'b0;
        sample(); chk("resume", {ce, addr}, {1'b1, 32'h0}); adv();
        sample(); chk("resume_head", {valid, pc, instr, fault}, {1'b1, 32'h0, 32'hA0, 1'b0}); adv();

        // Reset mid-stream.
        cyc(); cyc();
        do_reset();
        ready = 1'b1;
        sample(); chk("post_rst_idle", {ce, addr, valid}, {1'b0, RV, 1'b0}); adv();
        sample(); chk("post_rst_fetch", {ce, addr}, {1'b1, RV}); adv();

        // Random run against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            ready = ($urandom_range(3) != 0);
            redir = ($urandom_range(15) == 0);
            case ($urandom_range(3))
                0: tgt = $urandom_range(255) << 2;
                1: tgt = 32'h3F0;
                2: tgt = $urandom;
                default: tgt = $urandom_range(32'h3FF);
            endcase
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
